// File: rtl/csa_pkg.sv
// Shared types and defaults for the carry-save streaming accumulator.
package csa_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_ACC_W = 16;
    localparam int DEF_GROUP = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/csa_cla_adder.sv
// Combinational carry-lookahead adder: per-group generate/propagate with a
// group-carry chain, then bit sums rebuilt inside each group from its carry-in.
module csa_cla_adder #(
    parameter int ACC_W = 16,
    parameter int GROUP = 4
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             cin,
    output logic [ACC_W-1:0] sum,
    output logic             cout
);

    localparam int NG = ACC_W / GROUP;

    logic [ACC_W-1:0] g;
    logic [ACC_W-1:0] p;
    logic [NG:0]      gc;
    logic             grp_g;
    logic             grp_p;
    logic             c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gc    = '0;
        gc[0] = cin;
        sum   = '0;
        grp_g = 1'b0;
        grp_p = 1'b0;
        c     = 1'b0;
        // Group carries depend only on group G/P, never on bit-level ripple.
        for (int k = 0; k < NG; k++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                grp_g = g[k*GROUP+i] | (p[k*GROUP+i] & grp_g);
                grp_p = grp_p & p[k*GROUP+i];
            end
            gc[k+1] = grp_g | (grp_p & gc[k]);
        end
        for (int k = 0; k < NG; k++) begin
            c = gc[k];
            for (int i = 0; i < GROUP; i++) begin
                sum[k*GROUP+i] = p[k*GROUP+i] ^ c;
                c = g[k*GROUP+i] | (p[k*GROUP+i] & c);
            end
        end
    end

    assign cout = gc[NG];

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand adder: running total kept as sum/carry vectors,
// resolved by one registered CLA pass on the last operand of a packet.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ACCUM   | accepting operands, 3:2 compress into S/C each beat
// ST_RESOLVE | one cycle: S+C through the CLA into the output registers
// ST_HOLD    | result presented, waiting for out_ready; then clear and accept
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int GROUP = DEF_GROUP,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    state_e state_q, state_d;

    logic [ACC_W-1:0] s_q, s_d;
    logic [ACC_W-1:0] c_q, c_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] maj;
    logic [ACC_W-1:0] cla_sum;
    logic             cla_cout;

    always_comb begin
        x = '0;
        x[IN_W-1:0] = in_data;
        maj = '0;
        for (int i = 0; i < ACC_W; i++) begin
            maj[i] = maj3(s_q[i], c_q[i], x[i]);
        end
    end

    csa_cla_adder #(
        .ACC_W (ACC_W),
        .GROUP (GROUP)
    ) u_cla (
        .a    (s_q),
        .b    (c_q),
        .cin  (1'b0),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_count = out_count_q;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        ovf_acc_d   = ovf_acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    s_d = s_q ^ c_q ^ x;
                    c_d = maj << 1;
                    // The carry bit shifted out of the top is weight 2^ACC_W.
                    ovf_acc_d = ovf_acc_q | maj[ACC_W-1];
                    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                    if (in_last) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end
            ST_RESOLVE: begin
                out_data_d  = cla_sum;
                out_ovf_d   = ovf_acc_q | cla_cout;
                out_count_d = cnt_q;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    s_d       = '0;
                    c_d       = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            s_q         <= '0;
            c_q         <= '0;
            ovf_acc_q   <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            ovf_acc_q   <= ovf_acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: default 16-bit instance for directed cases and a
// 24-bit/GROUP=6 instance for randomised packets against a reference sum.
module tb_csa_accumulator;

    typedef struct packed {
        logic [23:0] data;
        logic        ovf;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][7:0]  ops;
        logic [15:0]      exp_data;
        logic             exp_ovf;
        logic [7:0]       exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic        iv = 1'b0, il = 1'b0, ordy = 1'b1;
    logic [7:0]  id = '0;
    logic        ir, ov, oo;
    logic [15:0] od;
    logic [7:0]  oc;

    logic        iv2 = 1'b0, il2 = 1'b0, ordy2 = 1'b1;
    logic [7:0]  id2 = '0;
    logic        ir2, ov2, oo2;
    logic [23:0] od2;
    logic [7:0]  oc2;

    exp_t q16[$];
    exp_t q24[$];

    csa_accumulator dut (
        .clk(clk), .rst(rst),
        .in_valid(iv), .in_ready(ir), .in_data(id), .in_last(il),
        .out_valid(ov), .out_ready(ordy), .out_data(od), .out_ovf(oo), .out_count(oc)
    );

    csa_accumulator #(.IN_W(8), .ACC_W(24), .GROUP(6), .CNT_W(8)) dut24 (
        .clk(clk), .rst(rst),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_last(il2),
        .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_ovf(oo2), .out_count(oc2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards: pop on every output handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && ov && ordy) begin
            if (q16.size() == 0) begin
                tests++; failed++;
                $display("FAIL sb16_unexpected: got result %0h, expected none", od);
            end else begin
                e = q16.pop_front();
                chk("sb16_data", 32'(od), 32'(e.data[15:0]));
                chk("sb16_ovf", 32'(oo), 32'(e.ovf));
                chk("sb16_count", 32'(oc), 32'(e.cnt));
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && ov2 && ordy2) begin
            if (q24.size() == 0) begin
                tests++; failed++;
                $display("FAIL sb24_unexpected: got result %0h, expected none", od2);
            end else begin
                e = q24.pop_front();
                chk("sb24_data", 32'(od2), 32'(e.data));
                chk("sb24_ovf", 32'(oo2), 32'(e.ovf));
                chk("sb24_count", 32'(oc2), 32'(e.cnt));
            end
        end
    end

    task automatic beat16(input logic [7:0] d, input logic last);
        int n = 0;
        iv = 1'b1; id = d; il = last;
        @(negedge clk);
        while (!ir && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin
            tests++; failed++;
            $display("FAIL beat16_timeout: in_ready got 0, expected 1");
        end
        @(posedge clk); #1;
        iv = 1'b0; il = 1'b0; id = 8'($urandom);
    endtask

    task automatic beat24(input logic [7:0] d, input logic last);
        int n = 0;
        iv2 = 1'b1; id2 = d; il2 = last;
        @(negedge clk);
        while (!ir2 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin
            tests++; failed++;
            $display("FAIL beat24_timeout: in_ready got 0, expected 1");
        end
        @(posedge clk); #1;
        iv2 = 1'b0; il2 = 1'($urandom); id2 = 8'($urandom);
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (q16.size() != 0) begin
            tests++; failed++;
            $display("FAIL drain16_timeout: pending %0d, expected 0", q16.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic drain24();
        int n = 0;
        while (q24.size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (q24.size() != 0) begin
            tests++; failed++;
            $display("FAIL drain24_timeout: pending %0d, expected 0", q24.size());
        end
    endtask

    task automatic run_const16(input int n, input logic [7:0] v, input exp_t e);
        q16.push_back(e);
        for (int k = 0; k < n; k++) beat16(v, k == n - 1);
        drain16();
    endtask

    initial begin
        ordy2 = 1'b1;
        #3;
        forever begin
            @(posedge clk); #1;
            ordy2 = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        exp_t e;
        vecs[0] = '{n: 3'd3, ops: {8'd0, 8'd7, 8'd5, 8'd3}, exp_data: 16'd15, exp_ovf: 1'b0, exp_cnt: 8'd3};
        vecs[1] = '{n: 3'd4, ops: {8'd255, 8'd255, 8'd255, 8'd255}, exp_data: 16'd1020, exp_ovf: 1'b0, exp_cnt: 8'd4};
        vecs[2] = '{n: 3'd1, ops: {8'd0, 8'd0, 8'd0, 8'd0}, exp_data: 16'd0, exp_ovf: 1'b0, exp_cnt: 8'd1};
        vecs[3] = '{n: 3'd2, ops: {8'd0, 8'd0, 8'h80, 8'h80}, exp_data: 16'h0100, exp_ovf: 1'b0, exp_cnt: 8'd2};
        vecs[4] = '{n: 3'd4, ops: {8'h00, 8'h01, 8'hF0, 8'h0F}, exp_data: 16'h0100, exp_ovf: 1'b0, exp_cnt: 8'd4};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir), 32'd1);
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_out_data", 32'(od), 32'd0);
        chk("rst_out_ovf", 32'(oo), 32'd0);
        chk("rst_out_count", 32'(oc), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors, each with latency checks around the last beat.
        for (int v = 0; v < 5; v++) begin
            e = '{data: {8'd0, vecs[v].exp_data}, ovf: vecs[v].exp_ovf, cnt: vecs[v].exp_cnt};
            q16.push_back(e);
            for (int k = 0; k < int'(vecs[v].n); k++) beat16(vecs[v].ops[k], k == int'(vecs[v].n) - 1);
            chk("lat_valid_edgeN", 32'(ov), 32'd0);
            chk("lat_ready_edgeN", 32'(ir), 32'd0);
            @(posedge clk); #1;
            chk("lat_valid_edgeN1", 32'(ov), 32'd1);
            drain16();
            chk("post_hs_ready", 32'(ir), 32'd1);
        end

        // Long run: count saturates, total wraps.
        run_const16(300, 8'd255, '{data: 24'd10964, ovf: 1'b1, cnt: 8'd255});
        run_const16(257, 8'd255, '{data: 24'hFFFF, ovf: 1'b0, cnt: 8'd255});
        q16.push_back('{data: 24'h0000, ovf: 1'b1, cnt: 8'd255});
        for (int k = 0; k < 257; k++) beat16(8'd255, 1'b0);
        beat16(8'd1, 1'b1);
        drain16();

        // Single beat held in HOLD by backpressure.
        ordy = 1'b0;
        q16.push_back('{data: 24'h00AB, ovf: 1'b0, cnt: 8'd1});
        beat16(8'hAB, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ov), 32'd1);
            chk("hold_ready", 32'(ir), 32'd0);
            chk("hold_data", 32'(od), 32'h00AB);
            chk("hold_count", 32'(oc), 32'd1);
        end
        @(posedge clk); #1;
        ordy = 1'b1;
        @(posedge clk); #1;
        chk("hs_in_ready", 32'(ir), 32'd1);
        chk("hs_out_valid", 32'(ov), 32'd0);
        run_const16(2, 8'd1, '{data: 24'd2, ovf: 1'b0, cnt: 8'd2});

        // Reset mid-packet discards the partial sum.
        beat16(8'd9, 1'b0);
        beat16(8'd9, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(ov), 32'd0);
        chk("midrst_ready", 32'(ir), 32'd1);
        chk("midrst_data", 32'(od), 32'd0);
        chk("midrst_count", 32'(oc), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_const16(1, 8'd4, '{data: 24'd4, ovf: 1'b0, cnt: 8'd1});

        // Randomised packets on the 24-bit instance.
        for (int p = 0; p < 1000; p++) begin
            int n;
            longint sum;
            logic [7:0] ops[8];
            n = $urandom_range(1, 8);
            sum = 0;
            for (int k = 0; k < n; k++) begin
                ops[k] = 8'($urandom);
                sum += longint'(ops[k]);
            end
            e.data = sum[23:0];
            e.ovf  = (sum >= 64'd16777216);
            e.cnt  = 8'(n);
            q24.push_back(e);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                beat24(ops[k], k == n - 1);
            end
        end
        drain24();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
